// File: rtl/brp_resolver.sv
// brp_resolver - execute-side branch prediction resolver.
//   Queues the fetch-time prediction of every in-flight conditional branch,
//   compares it with the real outcome when the branch resolves in execute,
//   produces predictor feedback/update, redirects fetch on a mispredict and
//   flushes the wrong-path predictions still queued.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_valid/is_br/pred        branch prediction pushed at fetch
//   fetch_stall                   queue full, fetch must hold a branch
//   ex_valid/is_br/taken          branch resolving in execute
//   ex_target, ex_pc_next         taken target and fall-through PC
//   brp_ex, update                predictor feedback word and update strobe
//   redirect, redirect_pc         fetch restart request after a mispredict
//   underflow                     sticky: branch resolved with empty queue
//   br_count, mp_count            saturating statistics counters

package brp_pkg;
   typedef struct packed {
      logic mp_valid;
      logic mispredicted;
   } rv32i_brp_word;
endpackage

module brp_resolver
   import brp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_valid,
   input  logic              fetch_is_br,
   input  logic              fetch_pred,
   output logic              fetch_stall,
   input  logic              ex_valid,
   input  logic              ex_is_br,
   input  logic              ex_taken,
   input  logic [31:0]       ex_target,
   input  logic [31:0]       ex_pc_next,
   output rv32i_brp_word     brp_ex,
   output logic              update,
   output logic              redirect,
   output logic [31:0]       redirect_pc,
   output logic              underflow,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  mp_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] pred_q;
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW:0]      occ;     // pointers alone cannot tell full from empty
   logic             empty, pop, pop_ok, push, pred_ex, mp, flush;

   always_comb begin
      empty       = (occ == '0);
      fetch_stall = (occ == FULL);
      pop         = ex_valid & ex_is_br;
      pop_ok      = pop & ~empty;
      // An empty-queue resolve behaves as if predicted not-taken.
      pred_ex     = empty ? 1'b0 : pred_q[rd_ptr];
      mp          = pop & (pred_ex != ex_taken);
      flush       = mp;
      // A branch fetched while a mispredict resolves is on the wrong path.
      push        = fetch_valid & fetch_is_br & ~fetch_stall & ~flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_q       <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         occ          <= '0;
         brp_ex       <= '0;
         update       <= 1'b0;
         redirect     <= 1'b0;
         redirect_pc  <= '0;
         underflow    <= 1'b0;
         br_count     <= '0;
         mp_count     <= '0;
      end else begin
         if (push) begin
            pred_q[wr_ptr] <= fetch_pred;
            wr_ptr         <= wr_ptr + AW'(1);
         end
         if (flush) begin
            // Everything behind the mispredicted head is wrong-path.
            occ    <= '0;
            rd_ptr <= wr_ptr;
         end else begin
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop_ok);
         end

         brp_ex.mp_valid     <= pop;
         brp_ex.mispredicted <= mp;
         update              <= pop;
         redirect            <= mp;
         if (mp) redirect_pc <= ex_taken ? ex_target : ex_pc_next;

         if (pop & empty) underflow <= 1'b1;
         if (pop && br_count != '1) br_count <= br_count + CNT_W'(1);
         if (mp  && mp_count != '1) mp_count <= mp_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_brp_resolver.sv
// tb_brp_resolver - directed self-checking bench for brp_resolver.
//   A default instance (DEPTH=4, CNT_W=32) and a CNT_W=4 instance share the
//   stimulus; the narrow one exercises counter saturation.

module tb_brp_resolver;
   import brp_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, fetch_valid, fetch_is_br, fetch_pred;
   logic        ex_valid, ex_is_br, ex_taken;
   logic [31:0] ex_target, ex_pc_next;

   logic          fetch_stall, update, redirect, underflow;
   rv32i_brp_word brp_ex;
   logic [31:0]   redirect_pc, br_count, mp_count;

   logic          fetch_stall4, update4, redirect4, underflow4;
   rv32i_brp_word brp_ex4;
   logic [31:0]   redirect_pc4;
   logic [3:0]    br_count4, mp_count4;

   int n_chk = 0;
   int n_fail = 0;

   brp_resolver #(.DEPTH(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_is_br(fetch_is_br), .fetch_pred(fetch_pred),
      .fetch_stall(fetch_stall),
      .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pc_next(ex_pc_next),
      .brp_ex(brp_ex), .update(update), .redirect(redirect), .redirect_pc(redirect_pc),
      .underflow(underflow), .br_count(br_count), .mp_count(mp_count)
   );

   brp_resolver #(.DEPTH(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_is_br(fetch_is_br), .fetch_pred(fetch_pred),
      .fetch_stall(fetch_stall4),
      .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pc_next(ex_pc_next),
      .brp_ex(brp_ex4), .update(update4), .redirect(redirect4), .redirect_pc(redirect_pc4),
      .underflow(underflow4), .br_count(br_count4), .mp_count(mp_count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      fetch_valid = 0; fetch_is_br = 0; fetch_pred = 0;
      ex_valid = 0; ex_is_br = 0; ex_taken = 0;
      ex_target = 32'h0; ex_pc_next = 32'h0;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic p);
      fetch_valid = 1; fetch_is_br = 1; fetch_pred = p;
   endtask

   task automatic set_pop(input logic t, input logic [31:0] tgt, input logic [31:0] pcn);
      ex_valid = 1; ex_is_br = 1; ex_taken = t; ex_target = tgt; ex_pc_next = pcn;
   endtask

   task automatic push(input logic p);
      set_push(p); tick(); idle_in();
   endtask

   task automatic pop(input logic t, input logic [31:0] tgt, input logic [31:0] pcn);
      set_pop(t, tgt, pcn); tick(); idle_in();
   endtask

   initial begin
      idle_in();
      rst = 1;
      tick();
      rst = 0;

      // Reset state
      chk("rst_mp_valid", brp_ex.mp_valid, 0);
      chk("rst_mispred", brp_ex.mispredicted, 0);
      chk("rst_update", update, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_br_count", br_count, 0);
      chk("rst_mp_count", mp_count, 0);
      chk("rst_stall", fetch_stall, 0);

      // Correct predictions 1,0,1
      push(1); push(0); push(1);
      pop(1, 32'h10, 32'h4);
      chk("ok1_mp_valid", brp_ex.mp_valid, 1);
      chk("ok1_update", update, 1);
      chk("ok1_mispred", brp_ex.mispredicted, 0);
      chk("ok1_redirect", redirect, 0);
      pop(0, 32'h20, 32'h8);
      chk("ok2_mp_valid", brp_ex.mp_valid, 1);
      chk("ok2_mispred", brp_ex.mispredicted, 0);
      chk("ok2_redirect", redirect, 0);
      pop(1, 32'h30, 32'hc);
      chk("ok3_update", update, 1);
      chk("ok3_mispred", brp_ex.mispredicted, 0);
      // Non-valid execute branch must be ignored
      ex_is_br = 1; tick(); idle_in();
      chk("nop_mp_valid", brp_ex.mp_valid, 0);
      chk("nop_update", update, 0);
      chk("ok_br_count", br_count, 3);
      chk("ok_mp_count", mp_count, 0);
      chk("ok_underflow", underflow, 0);

      // Mispredict taken: preds 0,1,1, first resolves taken
      push(0); push(1); push(1);
      pop(1, 32'h0000_0100, 32'h0000_0004);
      chk("mpt_mispred", brp_ex.mispredicted, 1);
      chk("mpt_redirect", redirect, 1);
      chk("mpt_redirect_pc", redirect_pc, 32'h100);
      chk("mpt_mp_count", mp_count, 1);
      chk("mpt_br_count", br_count, 4);
      tick();
      chk("mpt_redirect_off", redirect, 0);
      chk("mpt_redirect_hold", redirect_pc, 32'h100);
      // Flushed queue: resolve not-taken sees default not-taken, no mispredict
      pop(0, 32'h0, 32'h0);
      chk("uf_underflow", underflow, 1);
      chk("uf_mispred", brp_ex.mispredicted, 0);
      chk("uf_br_count", br_count, 5);
      chk("uf_mp_count", mp_count, 1);

      // Mispredict not-taken: preds 1,1, first resolves not-taken
      push(1); push(1);
      pop(0, 32'h0000_5000, 32'h0000_2004);
      chk("mpn_redirect", redirect, 1);
      chk("mpn_redirect_pc", redirect_pc, 32'h2004);
      chk("mpn_mp_count", mp_count, 2);
      pop(0, 32'h0, 32'h0);
      chk("mpn_discarded", brp_ex.mispredicted, 0);
      chk("mpn_br_count", br_count, 7);

      // Full queue, preds 1,0,0,1
      push(1); push(0); push(0); push(1);
      chk("full_stall", fetch_stall, 1);
      set_push(1); set_pop(1, 32'h0, 32'h0);
      #1;
      chk("full_stall_same_cycle", fetch_stall, 1);
      tick(); idle_in();
      chk("full_pop_mispred", brp_ex.mispredicted, 0);
      chk("full_pop_valid", brp_ex.mp_valid, 1);
      chk("full_after_stall", fetch_stall, 0);
      // Queue now 0,0,1; push 0 while popping head 0 -> 0,1,0
      set_push(0); set_pop(0, 32'h0, 32'h0);
      tick(); idle_in();
      chk("pp_mispred", brp_ex.mispredicted, 0);
      chk("pp_stall", fetch_stall, 0);
      pop(0, 32'h0, 32'h0);
      chk("wrap_a_mispred", brp_ex.mispredicted, 0);
      pop(1, 32'h0, 32'h0);
      chk("wrap_b_mispred", brp_ex.mispredicted, 0);
      pop(0, 32'h0, 32'h0);
      chk("wrap_c_mispred", brp_ex.mispredicted, 0);
      // Drained: taken resolve against default not-taken mispredicts
      pop(1, 32'h0000_0300, 32'h0000_0044);
      chk("drain_mispred", brp_ex.mispredicted, 1);
      chk("drain_redirect_pc", redirect_pc, 32'h300);
      chk("drain_br_count", br_count, 13);
      chk("drain_mp_count", mp_count, 3);

      // Flush drops same-cycle push
      push(1);
      set_push(1); set_pop(0, 32'h0, 32'h0000_0808);
      tick(); idle_in();
      chk("fp_mispred", brp_ex.mispredicted, 1);
      chk("fp_redirect_pc", redirect_pc, 32'h808);
      pop(0, 32'h0, 32'h0);
      chk("fp_dropped", brp_ex.mispredicted, 0);
      chk("fp_br_count", br_count, 15);
      chk("fp_mp_count", mp_count, 4);
      chk("fp_br_count4", 32'(br_count4), 15);
      chk("fp_mp_count4", 32'(mp_count4), 4);

      // 16 mispredicts: narrow counters saturate
      for (int i = 0; i < 16; i++) pop(1, 32'h0000_0abc, 32'h0);
      chk("sat_mp_count4", 32'(mp_count4), 15);
      chk("sat_br_count4", 32'(br_count4), 15);
      chk("sat_mp_count", mp_count, 20);
      chk("sat_br_count", br_count, 31);
      chk("sat_redirect_pc", redirect_pc, 32'habc);

      // Reset with two entries queued and competing events
      push(1); push(1);
      rst = 1; set_push(1); set_pop(0, 32'h0, 32'h0000_1234);
      tick(); idle_in();
      rst = 0;
      chk("mrst_mp_valid", brp_ex.mp_valid, 0);
      chk("mrst_mispred", brp_ex.mispredicted, 0);
      chk("mrst_update", update, 0);
      chk("mrst_redirect", redirect, 0);
      chk("mrst_redirect_pc", redirect_pc, 0);
      chk("mrst_underflow", underflow, 0);
      chk("mrst_br_count", br_count, 0);
      chk("mrst_mp_count", mp_count, 0);
      chk("mrst_mp_count4", 32'(mp_count4), 0);
      chk("mrst_stall", fetch_stall, 0);
      pop(0, 32'h0, 32'h0);
      chk("mrst_empty_mispred", brp_ex.mispredicted, 0);
      chk("mrst_empty_underflow", underflow, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/brp_resolver.md
Name: brp_resolver

Overview:
- Execute-side counterpart of the branch predictor: holds the prediction made at fetch for each in-flight branch and compares it with the actual outcome when the branch resolves in execute.
- Produces the brp_ex feedback word (mp_valid, mispredicted) and the update strobe that train the predictor.
- Issues a fetch redirect on misprediction and flushes wrong-path predictions.
- Keeps branch and mispredict statistics counters for performance debug.

Parameters:
DEPTH, 4, number of in-flight branch predictions held (power of two, >= 2)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
fetch_valid  input  1  fetch stage presents an instruction this cycle
fetch_is_br  input  1  fetched instruction is a conditional branch
fetch_pred  input  1  prediction given to the branch at fetch (1 = taken)
fetch_stall  output  1  prediction queue full; fetch must hold a branch
ex_valid  input  1  execute stage holds a valid instruction
ex_is_br  input  1  execute instruction is a conditional branch
ex_taken  input  1  actual branch outcome
ex_target  input  32  computed branch target
ex_pc_next  input  32  PC + 4 of the executing branch
brp_ex  output  rv32i_brp_word  fields driven: mp_valid, mispredicted
update  output  1  predictor state-update strobe
redirect  output  1  fetch must restart at redirect_pc
redirect_pc  output  32  correct next PC after a mispredict
underflow  output  1  sticky: a branch resolved with an empty queue
br_count  output  CNT_W  resolved branches
mp_count  output  CNT_W  mispredicted branches

Behaviour:
- Reset: queue empty, read/write pointers 0. All outputs 0: brp_ex fields, update, redirect, redirect_pc, underflow, both counters.
- Push:
  - Occurs when fetch_valid & fetch_is_br & !fetch_stall & !flush.
  - Writes fetch_pred at the write pointer. Pointers wrap modulo DEPTH.
  - A separate occupancy counter (0..DEPTH) distinguishes full from empty.
- fetch_stall: combinational; high when occupancy == DEPTH.
- Pop: occurs when ex_valid & ex_is_br. Reads the head entry as pred_ex.
- Empty pop: if the queue is empty, pred_ex = 0 (not-taken), underflow sets and stays set until rst, and pointers/occupancy stay unchanged.
- Mispredict: mp = pop & (pred_ex != ex_taken).
- Registered outputs, latched at the clock edge of the resolving cycle:
  - Every pop gives one-cycle pulses: brp_ex.mp_valid = 1, update = 1, brp_ex.mispredicted = mp.
  - If mp: redirect pulses 1 and redirect_pc = ex_taken ? ex_target : ex_pc_next.
  - Otherwise redirect = 0 and redirect_pc holds its last value.
  - With no pop, mp_valid, update, mispredicted and redirect are 0.
- Flush:
  - flush = pop & mp, combinational.
  - On flush, all entries younger than the popped head are discarded: occupancy -> 0, read pointer = write pointer.
  - A push in the same cycle as a flush is dropped, because it is wrong-path.
- Simultaneous push and pop without flush: occupancy unchanged, both pointers advance. This is legal when full (fetch_stall blocks the push only).
- Counters:
  - br_count increments on every pop.
  - mp_count increments on every mp.
  - Both saturate at all-ones (no wrap).
- Non-branch execute instructions (ex_is_br = 0) and ex_valid = 0 never touch the queue or the outputs.
- rst asserted mid-operation overrides all events in that cycle. Queue and outputs return to reset values on the next edge.

Test Plan:
- Push 3 branches with predictions 1,0,1; resolve them with outcomes 1,0,1 -> three one-cycle pulses of mp_valid=1/update=1, mispredicted=0 each, redirect never 1, br_count=3, mp_count=0.
- Push predictions 0,1,1; resolve the first with ex_taken=1, ex_target=0x0000_0100 -> next cycle mispredicted=1, redirect=1, redirect_pc=0x100, occupancy 0, mp_count=1. A following branch resolved with an empty queue sets underflow=1.
- Push predictions 1,1; resolve the first with ex_taken=0, ex_pc_next=0x0000_2004 -> redirect_pc=0x2004 one cycle later, and the second entry is discarded.
- Push 4 branches with DEPTH=4 -> fetch_stall=1. Then a pop and a push in the same cycle -> fetch_stall stays 1, and the FIFO order of the remaining predictions is preserved across pointer wrap.
- Mispredicting pop in the same cycle as fetch pushes pred=1 -> push dropped, occupancy 0 afterwards.
- Preload mp_count near saturation (CNT_W=4): 16 mispredicts -> mp_count=15. Assert rst while 2 entries are queued -> next cycle all outputs 0, queue empty.
